seven_seg_scan_driver: RTL



---
 rtl/seg_scan_pkg.sv | 13 +
 rtl/seg_scan_timer.sv | 46 ++++
 rtl/seven_seg_scan_driver.sv | 109 ++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: BCD nibble type and active-high 7-segment patterns ({a..g}, bit6 = a).
package seg_scan_pkg;
  typedef logic [3:0] bcd_t;
  localparam logic [6:0] SEG_DIGIT [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  function automatic logic [6:0] bcd_to_seg(input bcd_t nib);
    return (nib > 4'd9) ? SEG_DASH : SEG_DIGIT[nib];
  endfunction
endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: slot counter, digit index, frame_end and on_window strobes.
// Optional SEG_SCAN_BRIGHTNESS_EN trims the ON window by a 4-bit brightness level.
module seg_scan_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 168,
  parameter int BLANK_CYCLES = 8,
  localparam int IW = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]    brightness_i,
`endif
  output logic [IW-1:0] digit_o,
  output logic          frame_end_o,
  output logic          on_window_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          slot_end;
  always_comb begin
    slot_end    = cnt_q == CW'(REFRESH_DIV - 1);
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = !slot_end ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    frame_end_o = slot_end && idx_q == IW'(NUM_DIGITS - 1);
`ifdef SEG_SCAN_BRIGHTNESS_EN
    // ON time scales as (brightness+1)/16 of the post-blank part of the slot
    on_window_o = 32'(cnt_q) >= 32'(BLANK_CYCLES) &&
                  ((32'(cnt_q) - 32'(BLANK_CYCLES)) << 4) <
                  (32'(brightness_i) + 32'd1) * 32'(REFRESH_DIV - BLANK_CYCLES);
`else
    on_window_o = 32'(cnt_q) >= 32'(BLANK_CYCLES);
`endif
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end
  assign digit_o = idx_q;
endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed BCD 7-segment scanner with frame-aligned word commit.
// Define SEG_SCAN_BRIGHTNESS_EN to add the brightness input.
module seven_seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 168,
  parameter int BLANK_CYCLES   = 8,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bcd_valid,
  output logic                    bcd_ready,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
`ifdef SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]              brightness,
`endif
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   display_select
);
  localparam int IW = $clog2(NUM_DIGITS);
  if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || REFRESH_DIV <= BLANK_CYCLES || BLANK_CYCLES < 0)
    $error("seven_seg_scan_driver: illegal parameter combination");
  logic [IW-1:0]           idx;
  logic                    frame_end, on_window;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d, disp_q, disp_d;
  logic [NUM_DIGITS-1:0]   pdp_q, pdp_d, ddp_q, ddp_d;
  logic                    plz_q, plz_d, dlz_q, dlz_d;
  logic                    full_q, full_d, loaded_q, loaded_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d, blank;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    take, commit, active, lz_run;
  seg_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
`ifdef SEG_SCAN_BRIGHTNESS_EN
    .brightness_i(brightness),
`endif
    .digit_o     (idx),
    .frame_end_o (frame_end),
    .on_window_o (on_window)
  );
  // A digit is blanked when it and every more significant digit are zero
  always_comb begin
    blank  = '0;
    lz_run = dlz_q;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lz_run   = lz_run && (disp_q[4*i +: 4] == 4'd0);
      blank[i] = lz_run;
    end
  end
  always_comb begin
    take     = bcd_valid && !full_q;
    commit   = frame_end && full_q;
    full_d   = take || (full_q && !commit);
    pend_d   = take ? bcd_in : pend_q;
    pdp_d    = take ? dp_in : pdp_q;
    plz_d    = take ? blank_lz : plz_q;
    disp_d   = commit ? pend_q : disp_q;
    ddp_d    = commit ? pdp_q : ddp_q;
    dlz_d    = commit ? plz_q : dlz_q;
    loaded_d = loaded_q || commit;
    active   = on_window && loaded_q && !blank[idx];
    sel_d    = active ? NUM_DIGITS'(1) << idx : '0;
    seg_d    = active ? bcd_to_seg(disp_q[4*idx +: 4]) : SEG_OFF;
    dp_d     = active && ddp_q[idx];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q   <= '0;
      pdp_q    <= '0;
      plz_q    <= 1'b0;
      full_q   <= 1'b0;
      disp_q   <= '0;
      ddp_q    <= '0;
      dlz_q    <= 1'b0;
      loaded_q <= 1'b0;
      sel_q    <= '0;
      seg_q    <= SEG_OFF;
      dp_q     <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pdp_q    <= pdp_d;
      plz_q    <= plz_d;
      full_q   <= full_d;
      disp_q   <= disp_d;
      ddp_q    <= ddp_d;
      dlz_q    <= dlz_d;
      loaded_q <= loaded_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end
  assign bcd_ready      = !full_q;
  assign segments       = seg_q ^ {7{SEG_ACTIVE_LOW != 0}};
  assign dp             = dp_q ^ (SEG_ACTIVE_LOW != 0);
  assign display_select = sel_q ^ {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
endmodule
